alu_recv: RTL and testbench

ALU_RECV -- requirements
Module: alu_recv

---
 rtl/alu_recv_pkg.sv | 49 ++++
 rtl/alu_recv_core.sv | 108 ++++++++++
 rtl/alu_recv.sv | 57 +++++
 tb/tb_alu_recv.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/alu_recv_pkg.sv
// alu_recv_pkg: shared constants for the alu_recv execute stage.
// Datapath width, ALU/load-store/jump/branch opcode encodings and NOP codes.
// Optional feature macro: ALU_RECV_SHIFT_EN (enables SLL/SRL/SRA).
package alu_recv_pkg;

  localparam int XLEN = 32;

  // NOP encodings: all-ones on each op field means "nothing to do"
  localparam logic [9:0] ALU_NOP = 10'h3FF;
  localparam logic [4:0] OP_NONE = 5'h1F;

  // ALU operation codes carried in alu_op[3:0]
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0001,
    ALU_SUB  = 4'b0010,
    ALU_SLL  = 4'b0011,
    ALU_SLT  = 4'b0100,
    ALU_SLTU = 4'b0101,
    ALU_XOR  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_OR   = 4'b1001,
    ALU_AND  = 4'b1010,
    ALU_LUI  = 4'b1011
  } alu_code_e;

  // Load/store codes
  localparam logic [4:0] LS_LB  = 5'b00000;
  localparam logic [4:0] LS_LH  = 5'b00001;
  localparam logic [4:0] LS_LW  = 5'b00011;
  localparam logic [4:0] LS_LBU = 5'b00100;
  localparam logic [4:0] LS_LHU = 5'b00101;
  localparam logic [4:0] LS_SB  = 5'b01000;
  localparam logic [4:0] LS_SH  = 5'b01001;
  localparam logic [4:0] LS_SW  = 5'b01011;

  // Jump codes
  localparam logic [4:0] J_JALR = 5'b00001;
  localparam logic [4:0] J_JAL  = 5'b00010;

  // Branch codes
  localparam logic [4:0] B_BEQ  = 5'b00000;
  localparam logic [4:0] B_BNE  = 5'b00001;
  localparam logic [4:0] B_BLT  = 5'b00010;
  localparam logic [4:0] B_BGE  = 5'b00011;
  localparam logic [4:0] B_BLTU = 5'b00101;
  localparam logic [4:0] B_BGEU = 5'b00110;

endpackage

// File: rtl/alu_recv_core.sv
// alu_recv_core: purely combinational execute logic -- ALU, branch
// comparator, effective-address and next-PC adders.
// Optional feature macro: ALU_RECV_SHIFT_EN (when undefined, shift codes
// decode as undefined and no shifter is built).
module alu_recv_core #(
  parameter int XLEN = alu_recv_pkg::XLEN
) (
  input  logic [9:0]      alu_op_i,
  input  logic [4:0]      ls_op_i,
  input  logic [4:0]      j_op_i,
  input  logic [4:0]      b_op_i,
  input  logic [XLEN-1:0] pc_in_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [XLEN-1:0] address_imm_i,
  output logic [XLEN-1:0] rd_o,
  output logic [XLEN-1:0] pc_out_o,
  output logic [XLEN-1:0] address_o
);
  import alu_recv_pkg::*;

  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_plus_imm;
  logic [XLEN-1:0] rs1_plus_imm;
  logic            is_jal;
  logic            is_jalr;
  logic            br_valid;
  logic            br_taken;
  logic            ls_valid;

  assign op_b         = alu_op_i[9] ? address_imm_i : rs2_i;
  assign pc_plus4     = pc_in_i + XLEN'(4);
  assign pc_plus_imm  = pc_in_i + address_imm_i;
  assign rs1_plus_imm = rs1_i + address_imm_i;
  assign is_jal       = (j_op_i == J_JAL);
  assign is_jalr      = (j_op_i == J_JALR);

  // ALU result; any nonzero alu_op[8:4] (including NOP) forces zero
  always_comb begin
    alu_res = '0;
    if (alu_op_i[8:4] == 5'b00000) begin
      case (alu_code_e'(alu_op_i[3:0]))
        ALU_ADD:  alu_res = rs1_i + op_b;
        ALU_SUB:  alu_res = rs1_i - op_b;
        ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1_i) < $signed(op_b))};
        ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (rs1_i < op_b)};
        ALU_XOR:  alu_res = rs1_i ^ op_b;
        ALU_OR:   alu_res = rs1_i | op_b;
        ALU_AND:  alu_res = rs1_i & op_b;
        ALU_LUI:  alu_res = op_b;
`ifdef ALU_RECV_SHIFT_EN
        ALU_SLL:  alu_res = rs1_i << op_b[4:0];
        ALU_SRL:  alu_res = rs1_i >> op_b[4:0];
        ALU_SRA:  alu_res = $unsigned($signed(rs1_i) >>> op_b[4:0]);
`endif
        default:  alu_res = '0;
      endcase
    end
  end

  // Branch decode and compare; undefined codes are simply not a branch
  always_comb begin
    br_valid = 1'b1;
    br_taken = 1'b0;
    case (b_op_i)
      B_BEQ:   br_taken = (rs1_i == rs2_i);
      B_BNE:   br_taken = (rs1_i != rs2_i);
      B_BLT:   br_taken = ($signed(rs1_i) <  $signed(rs2_i));
      B_BGE:   br_taken = ($signed(rs1_i) >= $signed(rs2_i));
      B_BLTU:  br_taken = (rs1_i <  rs2_i);
      B_BGEU:  br_taken = (rs1_i >= rs2_i);
      default: br_valid = 1'b0;
    endcase
  end

  // Load/store decode: only the listed codes produce an address
  always_comb begin
    ls_valid = 1'b0;
    case (ls_op_i)
      LS_LB, LS_LH, LS_LW, LS_LBU, LS_LHU,
      LS_SB, LS_SH, LS_SW: ls_valid = 1'b1;
      default:             ls_valid = 1'b0;
    endcase
  end

  // Next PC: jumps win over branches; fall-through is pc + 4
  always_comb begin
    pc_out_o = pc_plus4;
    if (is_jal)
      pc_out_o = pc_plus_imm;
    else if (is_jalr)
      pc_out_o = {rs1_plus_imm[XLEN-1:1], 1'b0};
    else if (br_valid && br_taken)
      pc_out_o = pc_plus_imm;
  end

  // rd: the jump link value overrides the ALU result
  always_comb begin
    rd_o = alu_res;
    if (is_jal || is_jalr)
      rd_o = pc_plus4;
  end

  assign address_o = ls_valid ? rs1_plus_imm : '0;

endmodule

// File: rtl/alu_recv.sv
// alu_recv: execute stage top. All results come from alu_recv_core and are
// registered here, giving one cycle of latency; reset is async active-low.
// Optional feature macro: ALU_RECV_SHIFT_EN (enables SLL/SRL/SRA in the core).
module alu_recv #(
  parameter int XLEN = alu_recv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [9:0]      alu_op,
  input  logic [4:0]      ls_op,
  input  logic [4:0]      j_op,
  input  logic [4:0]      b_op,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] address_imm,
  output logic [XLEN-1:0] rd,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] address
);
  import alu_recv_pkg::*;

  logic [XLEN-1:0] rd_d, pc_out_d, address_d;
  logic [XLEN-1:0] rd_q, pc_out_q, address_q;

  alu_recv_core #(.XLEN(XLEN)) u_core (
    .alu_op_i      (alu_op),
    .ls_op_i       (ls_op),
    .j_op_i        (j_op),
    .b_op_i        (b_op),
    .pc_in_i       (pc_in),
    .rs1_i         (rs1),
    .rs2_i         (rs2),
    .address_imm_i (address_imm),
    .rd_o          (rd_d),
    .pc_out_o      (pc_out_d),
    .address_o     (address_d)
  );

  // Output registers, cleared immediately while reset is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q      <= '0;
      pc_out_q  <= '0;
      address_q <= '0;
    end else begin
      rd_q      <= rd_d;
      pc_out_q  <= pc_out_d;
      address_q <= address_d;
    end
  end

  assign rd      = rd_q;
  assign pc_out  = pc_out_q;
  assign address = address_q;

endmodule

// File: tb/tb_alu_recv.sv
// tb_alu_recv: table-driven directed vectors for alu_recv plus hand-written
// reset sequences. Shift expectations follow ALU_RECV_SHIFT_EN.
module tb_alu_recv;

  localparam logic [9:0] ANOP = 10'h3FF;
  localparam logic [4:0] ONOP = 5'h1F;
`ifdef ALU_RECV_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [9:0]  alu_op;
  logic [4:0]  ls_op, j_op, b_op;
  logic [31:0] pc_in, rs1, rs2, address_imm;
  logic [31:0] rd, pc_out, address;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [9:0]  alu_op;
    logic [4:0]  ls_op;
    logic [4:0]  j_op;
    logic [4:0]  b_op;
    logic [31:0] pc_in;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] exp_rd;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[$];

  alu_recv #(.XLEN(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_op      (alu_op),
    .ls_op       (ls_op),
    .j_op        (j_op),
    .b_op        (b_op),
    .pc_in       (pc_in),
    .rs1         (rs1),
    .rs2         (rs2),
    .address_imm (address_imm),
    .rd          (rd),
    .pc_out      (pc_out),
    .address     (address)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic [9:0] a, input logic [4:0] l,
                     input logic [4:0] j, input logic [4:0] b, input logic [31:0] pc,
                     input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                     input logic [31:0] erd, input logic [31:0] epc, input logic [31:0] ead);
    vec_t v;
    v.name = nm; v.alu_op = a; v.ls_op = l; v.j_op = j; v.b_op = b;
    v.pc_in = pc; v.rs1 = r1; v.rs2 = r2; v.imm = im;
    v.exp_rd = erd; v.exp_pc = epc; v.exp_addr = ead;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [9:0] a, input logic [4:0] l, input logic [4:0] j,
                       input logic [4:0] b, input logic [31:0] pc, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] im);
    alu_op = a; ls_op = l; j_op = j; b_op = b;
    pc_in = pc; rs1 = r1; rs2 = r2; address_imm = im;
  endtask

  initial begin
    // name alu ls j b pc rs1 rs2 imm -> rd pc_out address
    add("addi",      10'h201, ONOP, ONOP, ONOP, 32'h100, 32'd1, 32'd0, 32'd1, 32'd2, 32'h104, 32'd0);
    add("lw",        ANOP, 5'b00011, ONOP, ONOP, 32'h0, 32'd13, 32'd0, 32'd1, 32'd0, 32'h4, 32'd14);
    add("jal",       ANOP, ONOP, 5'b00010, ONOP, 32'd3, 32'd0, 32'd0, 32'd1, 32'd7, 32'd4, 32'd0);
    add("bltu_nt",   ANOP, ONOP, ONOP, 5'b00101, 32'h6C, 32'd3, 32'd1, 32'd9, 32'd0, 32'h70, 32'd0);
    add("bltu_t",    ANOP, ONOP, ONOP, 5'b00101, 32'h6C, 32'd1, 32'd3, 32'd9, 32'd0, 32'h75, 32'd0);
    add("sub_wrap",  10'h002, ONOP, ONOP, ONOP, 32'h10, 32'd0, 32'd1, 32'd0, 32'hFFFFFFFF, 32'h14, 32'd0);
    add("add_wrap",  10'h001, ONOP, ONOP, ONOP, 32'h10, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd1, 32'h14, 32'd0);
    add("slt",       10'h004, ONOP, ONOP, ONOP, 32'h0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd1, 32'h4, 32'd0);
    add("sltu",      10'h005, ONOP, ONOP, ONOP, 32'h0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'h4, 32'd0);
    add("xor",       10'h006, ONOP, ONOP, ONOP, 32'h0, 32'h0000F0F0, 32'h00000FF0, 32'd0, 32'h0000FF00, 32'h4, 32'd0);
    add("or",        10'h009, ONOP, ONOP, ONOP, 32'h0, 32'h0000F0F0, 32'h00000FF0, 32'd0, 32'h0000FFF0, 32'h4, 32'd0);
    add("and",       10'h00A, ONOP, ONOP, ONOP, 32'h0, 32'h0000F0F0, 32'h00000FF0, 32'd0, 32'h000000F0, 32'h4, 32'd0);
    add("lui",       10'h20B, ONOP, ONOP, ONOP, 32'h0, 32'h5, 32'h7, 32'h12345000, 32'h12345000, 32'h4, 32'd0);
    add("alu_undef", 10'h00C, ONOP, ONOP, ONOP, 32'h0, 32'h5, 32'h7, 32'd0, 32'd0, 32'h4, 32'd0);
    add("alu_hibit", 10'h011, ONOP, ONOP, ONOP, 32'h0, 32'h5, 32'h7, 32'd0, 32'd0, 32'h4, 32'd0);
    add("jalr_pri",  10'h001, ONOP, 5'b00001, 5'b00000, 32'h200, 32'h1001, 32'h1001, 32'h10, 32'h204, 32'h1010, 32'd0);
    add("beq_t",     ANOP, ONOP, ONOP, 5'b00000, 32'h40, 32'd7, 32'd7, 32'h20, 32'd0, 32'h60, 32'd0);
    add("bne_nt",    ANOP, ONOP, ONOP, 5'b00001, 32'h40, 32'd7, 32'd7, 32'h20, 32'd0, 32'h44, 32'd0);
    add("blt_t",     ANOP, ONOP, ONOP, 5'b00010, 32'h40, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF0, 32'd0, 32'h30, 32'd0);
    add("bge_nt",    ANOP, ONOP, ONOP, 5'b00011, 32'h40, 32'hFFFFFFFF, 32'd1, 32'h20, 32'd0, 32'h44, 32'd0);
    add("bgeu_t",    ANOP, ONOP, ONOP, 5'b00110, 32'h40, 32'hFFFFFFFF, 32'd1, 32'h20, 32'd0, 32'h60, 32'd0);
    add("b_undef",   ANOP, ONOP, 5'b00011, 5'b00100, 32'h40, 32'd7, 32'd7, 32'h20, 32'd0, 32'h44, 32'd0);
    add("sb_neg",    ANOP, 5'b01000, ONOP, ONOP, 32'h0, 32'h100, 32'd0, 32'hFFFFFFFC, 32'd0, 32'h4, 32'hFC);
    add("ls_undef",  ANOP, 5'b00010, ONOP, ONOP, 32'h0, 32'h100, 32'd0, 32'h4, 32'd0, 32'h4, 32'd0);
    add("sll",       10'h003, ONOP, ONOP, ONOP, 32'h0, 32'd1, 32'h24, 32'd0, SHIFT_EN ? 32'h10 : 32'h0, 32'h4, 32'd0);
    add("srl",       10'h007, ONOP, ONOP, ONOP, 32'h0, 32'h80000000, 32'd4, 32'd0, SHIFT_EN ? 32'h08000000 : 32'h0, 32'h4, 32'd0);
    add("sra",       10'h008, ONOP, ONOP, ONOP, 32'h0, 32'h80000000, 32'd4, 32'd0, SHIFT_EN ? 32'hF8000000 : 32'h0, 32'h4, 32'd0);

    // Reset asserted from time zero: outputs must read zero with no clock edge
    reset = 1'b0;
    drive(10'h001, 5'b00011, ONOP, ONOP, 32'h100, 32'd5, 32'd6, 32'd1);
    #2;
    chk("rst_rd", rd, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_addr", address, 32'd0);
    // Held at zero across an edge while reset stays low
    @(posedge clk); #1;
    chk("rst_hold_rd", rd, 32'd0);
    chk("rst_hold_pc", pc_out, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].alu_op, vecs[i].ls_op, vecs[i].j_op, vecs[i].b_op,
            vecs[i].pc_in, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      @(posedge clk); #1;
      $display("vec %0d %s rd=%h pc_out=%h address=%h", i, vecs[i].name, rd, pc_out, address);
      chk({vecs[i].name, "_rd"}, rd, vecs[i].exp_rd);
      chk({vecs[i].name, "_pc"}, pc_out, vecs[i].exp_pc);
      chk({vecs[i].name, "_addr"}, address, vecs[i].exp_addr);
    end

    // Reset mid-operation: outputs clear between edges, then resume
    @(negedge clk);
    drive(10'h001, 5'b01011, ONOP, ONOP, 32'h80, 32'd5, 32'd6, 32'd2);
    @(posedge clk); #1;
    chk("mid_pre_rd", rd, 32'd11);
    chk("mid_pre_addr", address, 32'd7);
    #2;
    reset = 1'b0;
    #1;
    $display("mid reset rd=%h pc_out=%h address=%h", rd, pc_out, address);
    chk("mid_async_rd", rd, 32'd0);
    chk("mid_async_pc", pc_out, 32'd0);
    chk("mid_async_addr", address, 32'd0);
    @(posedge clk); #1;
    chk("mid_hold_rd", rd, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_release_noedge_pc", pc_out, 32'd0);
    @(posedge clk); #1;
    $display("resume rd=%h pc_out=%h address=%h", rd, pc_out, address);
    chk("resume_rd", rd, 32'd11);
    chk("resume_pc", pc_out, 32'h84);
    chk("resume_addr", address, 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
